// File: rtl/tick_prescaler.sv
// Programmable clock prescaler: one-cycle count-enable tick with a glitch-free divisor-load
// handshake. Define TICK_PRESCALER_HALF_EN to add the mid-period 'half' pulse output.
module tick_prescaler #(
    parameter int unsigned DIV_W       = 26,
    parameter int unsigned DIV_DEFAULT = 50000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             step,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_value,
    output logic             div_ack,
    output logic             div_err,
    output logic             tick,
    output logic             running
`ifdef TICK_PRESCALER_HALF_EN
    ,
    output logic             half
`endif
);

    localparam logic [DIV_W-1:0] DivInit = DIV_W'(DIV_DEFAULT);
    localparam logic [DIV_W-1:0] CntInit = DIV_W'(DIV_DEFAULT - 1);

    typedef enum logic [1:0] {StIdle, StPend, StDrop} load_state_t;

    load_state_t      state;
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] pend_reg;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] new_div;
    logic             cnt_zero;
    logic             apply;
    logic             accept;

    // A pending divisor lands only at a period boundary, or immediately while paused.
    always_comb begin
        cnt_zero = (cnt == '0);
        apply    = (state == StPend) && (!enable || cnt_zero);
        accept   = apply && (pend_reg != '0);
        new_div  = accept ? pend_reg : div_reg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= StIdle;
            div_reg  <= DivInit;
            pend_reg <= '0;
            cnt      <= CntInit;
            tick     <= 1'b0;
            div_ack  <= 1'b0;
            div_err  <= 1'b0;
            running  <= 1'b0;
        end else begin
            tick    <= 1'b0;
            div_ack <= 1'b0;
            div_err <= 1'b0;
            running <= enable;

            if (enable) begin
                if (cnt_zero) begin
                    tick <= 1'b1;
                    cnt  <= new_div - 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end else if (step || accept) begin
                tick <= step;
                cnt  <= new_div - 1'b1;
            end

            if (accept) begin
                div_reg <= pend_reg;
            end

            unique case (state)
                StIdle: begin
                    if (div_load) begin
                        pend_reg <= div_value;
                        state    <= StPend;
                    end
                end
                StPend: begin
                    if (apply) begin
                        div_ack <= 1'b1;
                        div_err <= (pend_reg == '0);
                        state   <= StDrop;
                    end
                end
                // Wait for the requester to drop div_load so one request yields one ack.
                StDrop: begin
                    if (!div_load) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef TICK_PRESCALER_HALF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            half <= 1'b0;
        end else begin
            half <= enable && (div_reg >= DIV_W'(2)) && (cnt == (div_reg >> 1));
        end
    end
`endif

endmodule
